// File: rtl/imem_dmem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data load/store.
// Optional macro FETCH_STARVE_GUARD_EN bounds how long continuous data traffic can starve fetch.
module imem_dmem_port_arbiter #(
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_wstrb,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        arb_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
        $error("MEM_LAT must be in 1..15");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    state_t      state_r;
    state_t      state_s;
    logic        grant_if_s;
    logic        grant_dm_s;
    logic        fetch_first_s;
    logic        resp_s;
    logic        owner_dm_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic [3:0]  cnt_r;
    logic        mem_en_r;
    logic        mem_we_r;
    logic        if_ready_r;
    logic        dm_ready_r;
    logic [31:0] if_rdata_r;
    logic [31:0] dm_rdata_r;
    logic        busy_r;

`ifdef FETCH_STARVE_GUARD_EN
    logic [3:0]  starve_r;

    // Count data grants that bypassed a waiting fetch; any fetch grant clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_r <= 4'd0;
        end else if (grant_if_s) begin
            starve_r <= 4'd0;
        end else if (grant_dm_s && if_req && (starve_r != 4'hF)) begin
            starve_r <= starve_r + 4'd1;
        end else begin
            starve_r <= starve_r;
        end
    end

    assign fetch_first_s = if_req && (starve_r == 4'(STARVE_LIMIT));
`else
    assign fetch_first_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and grant decode; data wins unless the starvation guard fires.
    always_comb begin
        state_s    = state_r;
        grant_if_s = 1'b0;
        grant_dm_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fetch_first_s) begin
                    grant_if_s = 1'b1;
                    state_s    = ST_ISSUE;
                end else if (dm_req) begin
                    grant_dm_s = 1'b1;
                    state_s    = ST_ISSUE;
                end else if (if_req) begin
                    grant_if_s = 1'b1;
                    state_s    = ST_ISSUE;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            // Always pass through WAIT so the capture edge lands MEM_LAT cycles after mem_en.
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    assign resp_s = (state_s == ST_RESP);

    // Owner/attribute latch, latency counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_dm_r <= 1'b0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            wstrb_r    <= 4'd0;
            cnt_r      <= 4'd0;
            mem_en_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            if_ready_r <= 1'b0;
            dm_ready_r <= 1'b0;
            if_rdata_r <= 32'd0;
            dm_rdata_r <= 32'd0;
            busy_r     <= 1'b0;
        end else begin
            if (grant_dm_s) begin
                owner_dm_r <= 1'b1;
                addr_r     <= dm_addr;
                wdata_r    <= dm_wdata;
                wstrb_r    <= dm_wstrb;
            end else if (grant_if_s) begin
                owner_dm_r <= 1'b0;
                addr_r     <= if_addr;
                wdata_r    <= 32'd0;
                wstrb_r    <= 4'd0;
            end
            if (state_r == ST_ISSUE) begin
                cnt_r <= 4'(MEM_LAT - 1);
            end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            mem_en_r   <= grant_dm_s | grant_if_s;
            mem_we_r   <= grant_dm_s & dm_we;
            if_ready_r <= resp_s & ~owner_dm_r;
            dm_ready_r <= resp_s & owner_dm_r;
            if_rdata_r <= (resp_s && !owner_dm_r) ? mem_rdata : 32'd0;
            dm_rdata_r <= (resp_s && owner_dm_r) ? mem_rdata : 32'd0;
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_wstrb = wstrb_r;
    assign if_ready  = if_ready_r;
    assign if_rdata  = if_rdata_r;
    assign dm_ready  = dm_ready_r;
    assign dm_rdata  = dm_rdata_r;
    assign arb_busy  = busy_r;

endmodule
